// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and request-status helper for the UART command responder.
// Pure definitions: no latency, no flow control.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_CHK     = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_ADDR    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  typedef enum logic [2:0] {
    S_HUNT,
    S_GET_CMD,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_CHK,
    S_EXEC,
    S_SEND
  } state_t;

  // Checks are ordered: a corrupted packet reports checksum before anything it decodes.
  function automatic logic [2:0] req_status(input logic [7:0] cmd,
                                            input logic [7:0] addr,
                                            input logic [7:0] data,
                                            input logic [7:0] chk,
                                            input int         nregs);
    logic [7:0] w_exp_chk;
    w_exp_chk = (cmd == CMD_WR) ? (cmd ^ addr ^ data) : (cmd ^ addr);
    if (chk != w_exp_chk) return ST_CHK;
    if (cmd != CMD_WR && cmd != CMD_RD) return ST_CMD;
    if (int'(addr) >= nregs) return ST_ADDR;
    return ST_OK;
  endfunction

endpackage

// File: rtl/uart_cmd_byte_fetch.sv
// Single-outstanding RX FIFO reader: rd_en -> byte_valid one cycle later, plus inter-byte timeout.
// Waits indefinitely on rx_empty; timeout only counts while i_count_en is high.
module uart_cmd_byte_fetch
  #(parameter int TIMEOUT_CYC = 100000)
  (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_want,
  input  logic       i_count_en,
  input  logic       i_rx_empty,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_rd_en,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_timeout
  );

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic          r_rd_q;
  logic [CW-1:0] r_cnt;
  logic          w_rd_en;

  // Blocking on r_rd_q keeps a single read in flight and lets the FSM act on a byte first.
  assign w_rd_en      = i_want && !i_rx_empty && !r_rd_q && !rst;
  assign o_rx_rd_en   = w_rd_en;
  assign o_byte_valid = r_rd_q;
  assign o_byte       = i_rx_data;
  assign o_timeout    = i_count_en && !r_rd_q && !w_rd_en &&
                        (r_cnt >= CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_rd_q <= w_rd_en;
      if (!i_count_en || r_rd_q) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(TIMEOUT_CYC)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes A5/CMD/ADDR/[DATA]/CHK requests, runs register reads/writes, emits A5/STATUS/B2/RCHK.
// CHK byte_valid -> first tx_wr_en two cycles later; tx_full stalls SEND with tx_data held.
module uart_cmd_responder
  import uart_cmd_pkg::*;
  #(
  parameter int NREGS       = 16,
  parameter int TIMEOUT_CYC = 100000
  )
  (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_empty,
  output logic               rx_rd_en,
  input  logic [7:0]         rx_data,
  input  logic               tx_full,
  output logic               tx_wr_en,
  output logic [7:0]         tx_data,
  output logic [NREGS*8-1:0] regs_o,
  output logic               busy,
  output logic               err_pulse,
  output logic [2:0]         err_code,
  output logic [7:0]         err_cnt
  );

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t     r_state;
  logic [7:0] r_cmd;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic [7:0] r_b2;
  logic [2:0] r_status;
  logic [1:0] r_idx;
  logic [7:0] r_regs [NREGS];
  logic       r_err_pulse;
  logic [2:0] r_err_code;
  logic [7:0] r_err_cnt;

  logic          w_want;
  logic          w_count_en;
  logic          w_byte_valid;
  logic [7:0]    w_byte;
  logic          w_timeout;
  logic [2:0]    w_status;
  logic [AW-1:0] w_ridx;
  logic [7:0]    w_err_cnt_nxt;
  logic          w_tx_fire;
  logic [7:0]    w_status_b;

  assign w_count_en    = (r_state == S_GET_CMD) || (r_state == S_GET_ADDR) ||
                         (r_state == S_GET_DATA) || (r_state == S_GET_CHK);
  assign w_want        = (r_state == S_HUNT) || w_count_en;
  assign w_status      = req_status(r_cmd, r_addr, r_data, w_byte, NREGS);
  assign w_ridx        = r_addr[AW-1:0];
  assign w_err_cnt_nxt = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;
  assign w_tx_fire     = (r_state == S_SEND) && !tx_full;
  assign w_status_b    = {5'd0, r_status};

  uart_cmd_byte_fetch #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_fetch (
    .clk          (clk),
    .rst          (rst),
    .i_want       (w_want),
    .i_count_en   (w_count_en),
    .i_rx_empty   (rx_empty),
    .i_rx_data    (rx_data),
    .o_rx_rd_en   (rx_rd_en),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_b2        <= '0;
      r_status    <= ST_OK;
      r_idx       <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= '0;
      r_err_cnt   <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        S_HUNT: begin
          if (w_byte_valid && w_byte == SYNC_BYTE) r_state <= S_GET_CMD;
        end
        S_GET_CMD: begin
          if (w_byte_valid) begin
            r_cmd   <= w_byte;
            r_state <= S_GET_ADDR;
          end
        end
        S_GET_ADDR: begin
          if (w_byte_valid) begin
            r_addr  <= w_byte;
            r_data  <= '0;
            r_state <= (r_cmd == CMD_WR) ? S_GET_DATA : S_GET_CHK;
          end
        end
        S_GET_DATA: begin
          if (w_byte_valid) begin
            r_data  <= w_byte;
            r_state <= S_GET_CHK;
          end
        end
        S_GET_CHK: begin
          // Status is settled here so err_pulse lines up with the EXEC cycle.
          if (w_byte_valid) begin
            r_status <= w_status;
            r_state  <= S_EXEC;
            if (w_status != ST_OK) begin
              r_err_pulse <= 1'b1;
              r_err_code  <= w_status;
              r_err_cnt   <= w_err_cnt_nxt;
            end
          end
        end
        S_EXEC: begin
          if (r_status != ST_OK) begin
            r_b2 <= 8'h00;
          end else if (r_cmd == CMD_WR) begin
            r_regs[w_ridx] <= r_data;
            r_b2           <= r_addr;
          end else begin
            r_b2 <= r_regs[w_ridx];
          end
          r_idx   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_tx_fire) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= S_HUNT;
          end
        end
        default: r_state <= S_HUNT;
      endcase
      if (w_timeout) begin
        r_state     <= S_HUNT;
        r_err_pulse <= 1'b1;
        r_err_code  <= ST_TIMEOUT;
        r_err_cnt   <= w_err_cnt_nxt;
      end
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (r_state == S_SEND) begin
      case (r_idx)
        2'd0:    tx_data = SYNC_BYTE;
        2'd1:    tx_data = w_status_b;
        2'd2:    tx_data = r_b2;
        default: tx_data = w_status_b ^ r_b2;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs_o[8*g +: 8] = r_regs[g];
  end

  assign tx_wr_en  = w_tx_fire;
  assign busy      = (r_state != S_HUNT);
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: FIFO models around the DUT, directed table, random packets, corner sequences.
module tb_uart_cmd_responder;

  localparam int NREGS = 16;
  localparam int TO    = 50;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx_empty = 1'b1;
  logic               rx_rd_en;
  logic [7:0]         rx_data = 8'h00;
  logic               tx_full = 1'b0;
  logic               tx_wr_en;
  logic [7:0]         tx_data;
  logic [NREGS*8-1:0] regs_o;
  logic               busy;
  logic               err_pulse;
  logic [2:0]         err_code;
  logic [7:0]         err_cnt;

  uart_cmd_responder #(.NREGS(NREGS), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_empty  (rx_empty),
    .rx_rd_en  (rx_rd_en),
    .rx_data   (rx_data),
    .tx_full   (tx_full),
    .tx_wr_en  (tx_wr_en),
    .tx_data   (tx_data),
    .regs_o    (regs_o),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];
  int         lat_q[$];
  int cyc = 0, last_rd_cyc = 0, n_rd = 0, rd_viol = 0, wr_viol = 0, pulse_seen = 0;
  bit rx_hold = 1'b0, tx_full_req = 1'b0, rand_bp = 1'b0;
  int n_tests = 0, n_fail = 0;

  logic [7:0] m_regs [NREGS];
  int m_cnt = 0, m_code = 0, m_err_total = 0;

  typedef struct {
    logic [63:0] b;     // request bytes, first byte in [63:56]
    int          len;
    logic [31:0] r;     // expected response, first byte in [31:24]
    int          code;
    int          cnt;
  } vec_t;

  // FIFO models: observe strobes mid-cycle, act on them just after the edge that consumed them.
  initial forever begin
    bit         sr, sw;
    logic [7:0] sd;
    @(negedge clk);
    sr = rx_rd_en;
    sw = tx_wr_en;
    sd = tx_data;
    if (sr && rx_empty) rd_viol++;
    if (sw && tx_full) wr_viol++;
    if (err_pulse) pulse_seen++;
    if (sr) begin
      last_rd_cyc = cyc;
      n_rd++;
    end
    if (sw && (tx_log.size() % 4 == 0)) lat_q.push_back(cyc - last_rd_cyc);
    @(posedge clk);
    #1;
    cyc++;
    if (sr && rx_q.size() > 0) rx_data = rx_q.pop_front();
    if (sw) tx_log.push_back(sd);
    rx_hold  = rand_bp && ($urandom_range(0, 3) == 0);
    rx_empty = (rx_q.size() == 0) || rx_hold;
    tx_full  = rand_bp ? ($urandom_range(0, 2) == 0) : tx_full_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t want < 500000", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [NREGS*8-1:0] e;
    for (int i = 0; i < NREGS; i++) e[8*i +: 8] = m_regs[i];
    n_tests++;
    if (regs_o !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, regs_o, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] tx_at(input int idx);
    if (idx < tx_log.size()) return tx_log[idx];
    return 8'hxx;
  endfunction

  // Reference: walk the byte stream packet by packet and apply the protocol rules directly.
  function automatic void model_stream(input logic [7:0] s[$]);
    int i = 0;
    logic [7:0] cmd, addr, data, chk, good, st, b2;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      cmd  = s[i+1];
      addr = s[i+2];
      if (cmd == 8'h01) begin
        data = s[i+3];
        chk  = s[i+4];
        good = cmd ^ addr ^ data;
        i += 5;
      end else begin
        data = 8'h00;
        chk  = s[i+3];
        good = cmd ^ addr;
        i += 4;
      end
      if (chk != good)                        st = 8'd1;
      else if (cmd != 8'h01 && cmd != 8'h02)  st = 8'd2;
      else if (int'(addr) >= NREGS)           st = 8'd3;
      else                                    st = 8'd0;
      if (st != 0)           b2 = 8'h00;
      else if (cmd == 8'h01) b2 = addr;
      else                   b2 = m_regs[addr];
      if (st == 0 && cmd == 8'h01) m_regs[addr] = data;
      if (st != 0) begin
        m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
        m_code = int'(st);
        m_err_total++;
      end
      exp_q.push_back(8'hA5);
      exp_q.push_back(st);
      exp_q.push_back(b2);
      exp_q.push_back(st ^ b2);
    end
  endfunction

  task automatic wait_resp(input int n, output bit ok);
    int t = 0;
    while ((tx_log.size() < n || busy) && t < 400) begin
      tick(1);
      t++;
    end
    ok = (t < 400);
  endtask

  task automatic run_stream(input logic [7:0] s[$], input string name);
    int base;
    bit ok;
    exp_q = {};
    model_stream(s);
    base = tx_log.size();
    foreach (s[j]) rx_q.push_back(s[j]);
    wait_resp(base + exp_q.size(), ok);
    check({name, " done"}, 32'(ok), 1);
    foreach (exp_q[j]) check($sformatf("%s tx%0d", name, j), 32'(tx_at(base + j)), 32'(exp_q[j]));
    check({name, " err_cnt"}, 32'(err_cnt), m_cnt);
    check({name, " err_code"}, 32'(err_code), m_code);
  endtask

  initial begin
    vec_t       tab [13];
    logic [7:0] s[$];
    logic [7:0] b, cmd, addr, data, chk;
    int         base, lbase, t, nb, r;
    bit         ok;

    tab[0]  = '{64'hA5_01_03_5C_5E_00_00_00, 5, 32'hA5_00_03_03, 0, 0};
    tab[1]  = '{64'hA5_02_03_01_00_00_00_00, 4, 32'hA5_00_5C_5C, 0, 0};
    tab[2]  = '{64'hA5_01_03_5C_00_00_00_00, 5, 32'hA5_01_00_01, 1, 1};
    tab[3]  = '{64'hA5_02_20_22_00_00_00_00, 4, 32'hA5_03_00_03, 3, 2};
    tab[4]  = '{64'hA5_07_03_04_00_00_00_00, 4, 32'hA5_02_00_02, 2, 3};
    tab[5]  = '{64'hA5_02_10_12_00_00_00_00, 4, 32'hA5_03_00_03, 3, 4};
    tab[6]  = '{64'hA5_01_0F_77_79_00_00_00, 5, 32'hA5_00_0F_0F, 3, 4};
    tab[7]  = '{64'hA5_02_0F_0D_00_00_00_00, 4, 32'hA5_00_77_77, 3, 4};
    tab[8]  = '{64'h00_FF_13_A5_02_03_01_00, 7, 32'hA5_00_5C_5C, 3, 4};
    tab[9]  = '{64'hA5_00_05_05_00_00_00_00, 4, 32'hA5_02_00_02, 2, 5};
    tab[10] = '{64'hA5_07_03_00_00_00_00_00, 4, 32'hA5_01_00_01, 1, 6};
    tab[11] = '{64'hA5_02_20_00_00_00_00_00, 4, 32'hA5_01_00_01, 1, 7};
    tab[12] = '{64'hA5_09_20_29_00_00_00_00, 4, 32'hA5_02_00_02, 2, 8};
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;

    tick(3);
    check("reset rx_rd_en", 32'(rx_rd_en), 0);
    check("reset tx_wr_en", 32'(tx_wr_en), 0);
    check("reset tx_data", 32'(tx_data), 0);
    check("reset busy", 32'(busy), 0);
    check("reset err_pulse", 32'(err_pulse), 0);
    check("reset err_code", 32'(err_code), 0);
    check("reset err_cnt", 32'(err_cnt), 0);
    check_regs("reset regs_o");
    rst = 1'b0;
    tick(2);

    for (int k = 0; k < 13; k++) begin
      s = {};
      for (int j = 0; j < tab[k].len; j++) s.push_back(tab[k].b[63-8*j -: 8]);
      exp_q = {};
      model_stream(s);
      base  = tx_log.size();
      lbase = lat_q.size();
      foreach (s[j]) rx_q.push_back(s[j]);
      wait_resp(base + 4, ok);
      check($sformatf("vec%0d done", k), 32'(ok), 1);
      for (int j = 0; j < 4; j++)
        check($sformatf("vec%0d tx%0d", k, j), 32'(tx_at(base + j)), 32'(tab[k].r[31-8*j -: 8]));
      check($sformatf("vec%0d err_code", k), 32'(err_code), tab[k].code);
      check($sformatf("vec%0d err_cnt", k), 32'(err_cnt), tab[k].cnt);
      check($sformatf("vec%0d latency", k), (lat_q.size() > lbase) ? lat_q[lbase] : -1, 3);
      tick(2);
    end
    check_regs("table regs_o");

    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      s = {};
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        s.push_back(b);
      end
      r    = int'($urandom_range(0, 99));
      cmd  = (r < 50) ? 8'h01 : (r < 85) ? 8'h02 : 8'($urandom_range(0, 255));
      addr = ($urandom_range(0, 99) < 80) ? 8'($urandom_range(0, NREGS - 1)) : 8'($urandom_range(0, 255));
      data = 8'($urandom_range(0, 255));
      chk  = (cmd == 8'h01) ? (cmd ^ addr ^ data) : (cmd ^ addr);
      if ($urandom_range(0, 99) < 15) chk = chk ^ 8'($urandom_range(1, 255));
      s.push_back(8'hA5);
      s.push_back(cmd);
      s.push_back(addr);
      if (cmd == 8'h01) s.push_back(data);
      s.push_back(chk);
      run_stream(s, $sformatf("rand%0d", k));
    end
    rand_bp = 1'b0;
    tick(4);
    check_regs("random regs_o");

    base = tx_log.size();
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h01);
    t = 0;
    while (!err_pulse && t < 200) begin
      tick(1);
      t++;
    end
    check("timeout pulse", 32'(err_pulse), 1);
    check("timeout code", 32'(err_code), 4);
    check("timeout busy", 32'(busy), 0);
    check("timeout delay window", 32'(t >= TO && t <= TO + 20), 1);
    m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
    m_code = 4;
    m_err_total++;
    tick(5);
    check("timeout no tx", tx_log.size(), base);
    check("timeout err_cnt", 32'(err_cnt), m_cnt);
    run_stream('{8'hA5, 8'h01, 8'h05, 8'h3C, 8'h38}, "post-timeout write");

    s = '{8'hA5, 8'h02, 8'h05, 8'h07};
    exp_q = {};
    model_stream(s);
    base = tx_log.size();
    foreach (s[j]) rx_q.push_back(s[j]);
    t = 0;
    while (tx_log.size() < base + 1 && t < 100) begin
      tick(1);
      t++;
    end
    tx_full_req = 1'b1;
    tick(10);
    tx_full_req = 1'b0;
    wait_resp(base + 4, ok);
    check("bp done", 32'(ok), 1);
    foreach (exp_q[j]) check($sformatf("bp tx%0d", j), 32'(tx_at(base + j)), 32'(exp_q[j]));
    check("bp read data", 32'(tx_at(base + 2)), 32'h3C);
    tick(10);
    check("bp no duplicates", tx_log.size(), base + 4);

    nb = n_rd;
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h01);
    t = 0;
    while (n_rd < nb + 2 && t < 50) begin
      tick(1);
      t++;
    end
    tick(3);
    check("pre-reset busy", 32'(busy), 1);
    rst = 1'b1;
    tick(1);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset err_cnt", 32'(err_cnt), 0);
    check("mid reset err_code", 32'(err_code), 0);
    check("mid reset err_pulse", 32'(err_pulse), 0);
    check("mid reset tx_wr_en", 32'(tx_wr_en), 0);
    check("mid reset tx_data", 32'(tx_data), 0);
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_cnt  = 0;
    m_code = 0;
    check_regs("mid reset regs_o");
    rst = 1'b0;
    tick(2);
    run_stream('{8'hA5, 8'h02, 8'h03, 8'h01}, "post-reset read");
    run_stream('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h10}, "post-reset write");
    tick(4);
    check_regs("final regs_o");

    check("rd_en while empty", rd_viol, 0);
    check("wr_en while full", wr_viol, 0);
    check("err_pulse count", pulse_seen, m_err_total);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
